// File: rtl/risc_v_mike_mmio_uart_bridge.sv
// rtl/risc_v_mike_mmio_uart_bridge.sv - memory-mapped multi-channel UART bridge with TX/RX FIFOs
module risc_v_mike_mmio_uart_bridge #(
    parameter int          NUM_CH     = 2,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                bus_addr,
    input  logic                       bus_write,
    input  logic                       bus_read,
    input  logic [31:0]                bus_wr_data,
    output logic [31:0]                bus_rd_data,
    output logic                       bus_sel,
    output logic [NUM_CH*DATA_W-1:0]   uart_tx_data,
    output logic [NUM_CH-1:0]          uart_tx_send,
    input  logic [NUM_CH-1:0]          uart_tx_flag,
    output logic [NUM_CH-1:0]          uart_tx_flag_clr,
    input  logic [NUM_CH*DATA_W-1:0]   uart_rx_data,
    input  logic [NUM_CH-1:0]          uart_rx_flag,
    output logic [NUM_CH-1:0]          uart_rx_flag_clr,
    output logic [NUM_CH-1:0]          irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(16 * NUM_CH);

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT, TX_CLR} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_DRAIN} rx_state_t;

    logic [2:0]  ch;
    logic [1:0]  offset;
    logic [31:0] ch_rd [NUM_CH];
    logic        unused_bits;

    // BASE_ADDR is 16-byte aligned, so the channel index is a 3-bit difference of bits [6:4]
    assign ch          = bus_addr[6:4] - BASE_ADDR[6:4];
    assign offset      = bus_addr[3:2];
    assign bus_sel     = (bus_addr >= BASE_ADDR) && ({1'b0, bus_addr} < END_ADDR);
    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wr_data};

    // load data mux: selected channel register, 0 outside the window
    always_comb begin
        bus_rd_data = 32'd0;
        if (bus_sel) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch == k[2:0]) bus_rd_data = ch_rd[k];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              sel_ch, wr_tx, wr_status, wr_ctrl, rd_rx;
        logic [3:0]        ctrl;
        logic              tx_ovf, rx_ovf;
        logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
        logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
        logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
        logic [CW-1:0]     tx_count, rx_count;
        logic              tx_full, tx_empty, rx_full, rx_empty;
        logic              tx_pop, tx_do_push, tx_drop;
        logic              rx_push, rx_pop, rx_do_push, rx_drop;
        logic [DATA_W-1:0] rx_in;
        tx_state_t         tx_state;
        rx_state_t         rx_state;
        logic [DATA_W-1:0] tx_data_q;
        logic              tx_send_q, tx_clr_q, rx_clr_q;
        logic [31:0]       status, rx_word;

        assign sel_ch    = bus_sel && (ch == 3'(i));
        assign wr_tx     = sel_ch && bus_write && (offset == 2'd0);
        assign rd_rx     = sel_ch && bus_read  && (offset == 2'd1);
        assign wr_status = sel_ch && bus_write && (offset == 2'd2);
        assign wr_ctrl   = sel_ch && bus_write && (offset == 2'd3);

        assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
        assign tx_empty = (tx_count == '0);
        assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
        assign rx_empty = (rx_count == '0);
        assign rx_in    = uart_rx_data[i*DATA_W +: DATA_W];

        // a pop in the same cycle frees a slot, so a push to a full FIFO then succeeds
        assign tx_pop     = (tx_state == TX_IDLE) && ctrl[0] && !tx_empty;
        assign tx_do_push = wr_tx && (!tx_full || tx_pop);
        assign tx_drop    = wr_tx && tx_full && !tx_pop;
        assign rx_push    = (rx_state == RX_IDLE) && uart_rx_flag[i] && ctrl[1];
        assign rx_pop     = rd_rx && !rx_empty;
        assign rx_do_push = rx_push && (!rx_full || rx_pop);
        assign rx_drop    = rx_push && rx_full && !rx_pop;

        // FIFO storage, contents need no reset
        always_ff @(posedge clk) begin
            if (tx_do_push) tx_mem[tx_wp] <= bus_wr_data[DATA_W-1:0];
            if (rx_do_push) rx_mem[rx_wp] <= rx_in;
        end

        // FIFO pointers and occupancy counts
        always_ff @(posedge clk) begin
            if (rst) begin
                tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
                rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
            end else begin
                if (tx_do_push) tx_wp <= tx_wp + AW'(1);
                if (tx_pop)     tx_rp <= tx_rp + AW'(1);
                if (tx_do_push && !tx_pop)      tx_count <= tx_count + CW'(1);
                else if (!tx_do_push && tx_pop) tx_count <= tx_count - CW'(1);
                if (rx_do_push) rx_wp <= rx_wp + AW'(1);
                if (rx_pop)     rx_rp <= rx_rp + AW'(1);
                if (rx_do_push && !rx_pop)      rx_count <= rx_count + CW'(1);
                else if (!rx_do_push && rx_pop) rx_count <= rx_count - CW'(1);
            end
        end

        // control register and sticky overflow bits; a new overflow beats a clear
        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl   <= 4'd0;
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end else begin
                if (wr_ctrl) ctrl <= bus_wr_data[3:0];
                if (tx_drop) tx_ovf <= 1'b1;
                else if (wr_status && bus_wr_data[4]) tx_ovf <= 1'b0;
                if (rx_drop) rx_ovf <= 1'b1;
                else if (wr_status && bus_wr_data[5]) rx_ovf <= 1'b0;
            end
        end

        // TX handshake: load/send, wait for done flag, clear it
        always_ff @(posedge clk) begin
            if (rst) begin
                tx_state  <= TX_IDLE;
                tx_data_q <= '0;
                tx_send_q <= 1'b0;
                tx_clr_q  <= 1'b0;
            end else begin
                tx_send_q <= 1'b0;
                tx_clr_q  <= 1'b0;
                case (tx_state)
                    TX_IDLE: if (tx_pop) begin
                        tx_data_q <= tx_mem[tx_rp];
                        tx_send_q <= 1'b1;
                        tx_state  <= TX_LOAD;
                    end
                    TX_LOAD: tx_state <= TX_WAIT;
                    TX_WAIT: if (uart_tx_flag[i]) begin
                        tx_clr_q <= 1'b1;
                        tx_state <= TX_CLR;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end

        // RX handshake: one push per flag assertion, then wait for the flag to fall
        always_ff @(posedge clk) begin
            if (rst) begin
                rx_state <= RX_IDLE;
                rx_clr_q <= 1'b0;
            end else begin
                rx_clr_q <= 1'b0;
                case (rx_state)
                    RX_IDLE: if (rx_push) begin
                        rx_clr_q <= 1'b1;
                        rx_state <= RX_CAPTURE;
                    end
                    RX_CAPTURE: rx_state <= RX_DRAIN;
                    RX_DRAIN: if (!uart_rx_flag[i]) rx_state <= RX_IDLE;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end

        assign status  = {8'd0, 8'(rx_count), 8'(tx_count), 2'b00,
                          rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
        assign rx_word = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp]);
        assign ch_rd[i] = (offset == 2'd1) ? rx_word :
                          (offset == 2'd2) ? status :
                          (offset == 2'd3) ? {28'd0, ctrl} : 32'd0;

        assign uart_tx_data[i*DATA_W +: DATA_W] = tx_data_q;
        assign uart_tx_send[i]     = tx_send_q;
        assign uart_tx_flag_clr[i] = tx_clr_q;
        assign uart_rx_flag_clr[i] = rx_clr_q;
        assign irq[i] = (ctrl[2] && !rx_empty) || (ctrl[3] && tx_empty && (tx_state == TX_IDLE));
    end

endmodule

// File: doc/risc_v_mike_mmio_uart_bridge.md
Name: risc_v_mike_mmio_uart_bridge

Overview:
Parametrised memory-mapped UART bridge for the risc_v_mike core. It replaces the fixed single-channel gpio_out/gpio_in UART hookup with NUM_CH channels. Each channel has a TX FIFO and an RX FIFO, plus handshake FSMs that drive the UART core's tx_send/tx_flag_clr/rx_flag_clr. It sits beside the data memory on the core's data bus (alu_result address, mem_write, rs2 write data) and claims an address window.

Parameters:
NUM_CH, 2, number of UART channels (1..8)
DATA_W, 8, UART character width (<=32)
FIFO_DEPTH, 8, entries per TX and per RX FIFO; power of 2, 2..128
BASE_ADDR, 32'h0000_0100, byte address of channel 0 registers; 16-byte aligned

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
bus_addr  in  32  byte address from ALU result
bus_write  in  1  store strobe, one access per cycle
bus_read  in  1  load strobe; qualifies RXDATA pop
bus_wr_data  in  32  store data
bus_rd_data  out  32  load data, combinational; 0 when bus_sel=0
bus_sel  out  1  combinational; bus_addr within [BASE_ADDR, BASE_ADDR+16*NUM_CH)
uart_tx_data  out  NUM_CH*DATA_W  per-channel TX character, registered
uart_tx_send  out  NUM_CH  one-cycle send pulse per channel
uart_tx_flag  in  NUM_CH  UART TX-done flag
uart_tx_flag_clr  out  NUM_CH  one-cycle TX flag clear pulse
uart_rx_data  in  NUM_CH*DATA_W  UART received character
uart_rx_flag  in  NUM_CH  UART RX-valid flag
uart_rx_flag_clr  out  NUM_CH  one-cycle RX flag clear pulse
irq  out  NUM_CH  per-channel interrupt, level

Behaviour:
- Reset: synchronous, active-high. All FIFOs empty. CTRL=0 and sticky bits=0. FSMs go to IDLE. All outputs 0, including uart_tx_data.
- Reset mid-frame drops queued data. Pending flags are not acknowledged.
- Decode: ch = (bus_addr-BASE_ADDR)>>4; offset = bus_addr[3:2]; bus_addr[1:0] ignored.
- Channel register map:
  - +0x0 TXDATA: W pushes bus_wr_data[DATA_W-1:0]. If TX FIFO is full, the data is dropped and tx_ovf is set. Reads return 0.
  - +0x4 RXDATA: R returns the RX head, zero-extended; returns 0 when empty. A read with bus_read=1 pops at the clock edge; a read while empty does not pop. Writes are ignored.
  - +0x8 STATUS (R):
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty
    - bit4 tx_ovf, bit5 rx_ovf
    - [15:8] tx_count, [23:16] rx_count; other bits 0
    - W: writing 1 to bit4/bit5 clears that sticky bit. A set and a clear in the same cycle leave the bit set.
  - +0xC CTRL (R/W bits[3:0]): bit0 tx_en, bit1 rx_en, bit2 irq_rx_en, bit3 irq_txe_en.
- FIFOs: circular, with count in $clog2(FIFO_DEPTH)+1 bits and wrap-around pointers.
  - Push and pop in the same cycle both occur and count is unchanged; when full, the pop frees the slot, so the push succeeds.
  - Pop of empty and push of full are suppressed.
- TX FSM (per channel):
  - IDLE: tx_en=1 and TX not empty -> LOAD.
  - LOAD (1 cycle): register head into uart_tx_data, pop, assert uart_tx_send -> WAIT.
  - WAIT: hold uart_tx_data; uart_tx_flag=1 -> CLR.
  - CLR (1 cycle): assert uart_tx_flag_clr -> IDLE.
  - Clearing tx_en mid-frame takes effect only in IDLE. Minimum 3 cycles per character plus the UART frame time.
- RX FSM (per channel):
  - IDLE: uart_rx_flag=1 and rx_en=1 -> CAPTURE.
  - CAPTURE (1 cycle): push uart_rx_data. If full, drop and set rx_ovf. Assert uart_rx_flag_clr -> DRAIN.
  - DRAIN: wait for uart_rx_flag=0 -> IDLE. This guarantees one push per flag assertion.
  - With rx_en=0 the flag is left pending, not cleared.
  - A CPU pop and an FSM push in the same cycle are legal.
- irq[ch] = (irq_rx_en & !rx_empty) | (irq_txe_en & tx_empty & TX FSM in IDLE). Combinational from registers.
- Channels are fully independent. Accesses outside the window: bus_sel=0, no side effects.

Test Plan:
- Reset, then read STATUS ch0 -> 0x0000_000A (tx_empty, rx_empty). CTRL=0, irq=0, all uart_* outputs 0.
- ch1 CTRL=1; store 0x41, 0x42 to TXDATA -> uart_tx_send[1] pulses with uart_tx_data=0x41. Bench raises tx_flag 20 cycles later -> uart_tx_flag_clr pulses one cycle, then the 0x42 send follows within 2 cycles. tx_empty=1 at the end.
- CTRL=0, push FIFO_DEPTH+1=9 bytes -> STATUS tx_count=8, tx_full=1, tx_ovf=1. Write STATUS 0x10 -> tx_ovf=0, count still 8.
- rx_en=1, irq_rx_en=1; bench presents 0x5A with rx_flag -> one uart_rx_flag_clr pulse. Flag held high 5 more cycles -> rx_count=1, not 2. irq=1; load RXDATA -> 0x0000_005A; irq=0.
- RX FIFO full (8) with a new flag arriving in the same cycle as an RXDATA pop -> count stays 8, rx_ovf=0, new byte is last in order.
- rst asserted during TX WAIT with 3 bytes queued -> next cycle tx_count=0, uart_tx_data=0, FSM IDLE, no uart_tx_flag_clr pulse.
